hazard_fwd_ctrl: RTL

Hazard and forwarding controller for the three-stage (D/X/W) RISC-V pipeline. It tracks the destination registers of in-flight instructions and drives the select inputs of the two ALU-operand 3:1 muxes. It also inserts one-cycle load-use bubbles, handles branch redirects and global memory stalls, and keeps a saturating stall counter for performance analysis.

---
 rtl/hazard_fwd_ctrl.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl
// Hazard and forwarding controller for a three-stage D/X/W pipeline.
// Tracks the destinations of in-flight instructions (X, W and the retired
// slot R), selects ALU operand sources, inserts load-use bubbles, honours
// branch redirects and global memory stalls, and counts inserted bubbles.
//
// Optional feature macro: HAZARD_RETIRE_FWD_EN
//   defined   : a dependency on the W-stage producer is forwarded from the
//               retired-result register (select 2).
//   undefined : select 2 is never produced; such a dependency stalls D for a
//               cycle and the consumer later reads the register file.
//
// Handshake: d_ready is combinational and means "the D instruction is
// accepted into X on this clock edge". It is only ever high when d_valid is
// high, no hazard is pending, no redirect is taken and memory is not stalled.
// Fetch must hold the D instruction stable while d_valid && !d_ready, except
// on x_redirect where it discards D.
//
// dbg_shadow exposes the shadow pipeline state for checkers:
//   {x_v, x_rd, x_wen, x_load, w_v, w_rd, w_wen, r_v, r_rd, r_wen}

module hazard_fwd_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    d_valid,
    input  logic [REG_ADDR_W-1:0]   d_rs1,
    input  logic [REG_ADDR_W-1:0]   d_rs2,
    input  logic                    d_rs1_used,
    input  logic                    d_rs2_used,
    input  logic [REG_ADDR_W-1:0]   d_rd,
    input  logic                    d_wen,
    input  logic                    d_is_load,
    input  logic                    x_redirect,
    input  logic                    mem_stall,
    output logic                    d_ready,
    output logic                    x_bubble,
    output logic [1:0]              fwd_a_sel,
    output logic [1:0]              fwd_b_sel,
    output logic [CNT_W-1:0]        stall_cnt,
    output logic [3*REG_ADDR_W+6:0] dbg_shadow
);

    localparam logic [1:0] SEL_RF  = 2'd0;
    localparam logic [1:0] SEL_W   = 2'd1;
    localparam logic [1:0] SEL_RET = 2'd2;

    // Shadow state of the instructions currently in X, W and just retired
    logic                  x_v, x_wen, x_load;
    logic [REG_ADDR_W-1:0] x_rd;
    logic                  w_v, w_wen;
    logic [REG_ADDR_W-1:0] w_rd;
    logic                  r_v, r_wen;
    logic [REG_ADDR_W-1:0] r_rd;

    logic       m1_x, m1_w, m2_x, m2_w;
    logic       ld_hazard, ret_hazard, hazard;
    logic [1:0] sel_a, sel_b;

    // Dependency matching, hazard detection, issue decision and operand selects
    always_comb begin
        m1_x = d_rs1_used && (d_rs1 != '0) && (d_rs1 == x_rd) && x_v && x_wen;
        m1_w = d_rs1_used && (d_rs1 != '0) && (d_rs1 == w_rd) && w_v && w_wen;
        m2_x = d_rs2_used && (d_rs2 != '0) && (d_rs2 == x_rd) && x_v && x_wen;
        m2_w = d_rs2_used && (d_rs2 != '0) && (d_rs2 == w_rd) && w_v && w_wen;

        ld_hazard = d_valid && x_load && (m1_x || m2_x);
`ifdef HAZARD_RETIRE_FWD_EN
        ret_hazard = 1'b0;
`else
        // Without the retire path, an operand whose nearest producer is in W
        // must wait until that producer has written the register file.
        ret_hazard = d_valid && ((m1_w && !m1_x) || (m2_w && !m2_x));
`endif
        hazard  = ld_hazard || ret_hazard;
        d_ready = d_valid && !hazard && !x_redirect && !mem_stall;

        // Nearest producer wins: X beats W
        sel_a = SEL_RF;
        sel_b = SEL_RF;
        if (m1_x) begin
            sel_a = SEL_W;
        end else if (m1_w) begin
`ifdef HAZARD_RETIRE_FWD_EN
            sel_a = SEL_RET;
`else
            sel_a = SEL_RF;
`endif
        end
        if (m2_x) begin
            sel_b = SEL_W;
        end else if (m2_w) begin
`ifdef HAZARD_RETIRE_FWD_EN
            sel_b = SEL_RET;
`else
            sel_b = SEL_RF;
`endif
        end
    end

    // Pipeline shadow, registered selects and saturating bubble counter
    always_ff @(posedge clk) begin
        if (rst) begin
            x_v       <= 1'b0;
            x_rd      <= '0;
            x_wen     <= 1'b0;
            x_load    <= 1'b0;
            w_v       <= 1'b0;
            w_rd      <= '0;
            w_wen     <= 1'b0;
            r_v       <= 1'b0;
            r_rd      <= '0;
            r_wen     <= 1'b0;
            x_bubble  <= 1'b1;
            fwd_a_sel <= SEL_RF;
            fwd_b_sel <= SEL_RF;
            stall_cnt <= '0;
        end else if (!mem_stall) begin
            r_v   <= w_v;
            r_rd  <= w_rd;
            r_wen <= w_wen;
            w_v   <= x_v;
            w_rd  <= x_rd;
            w_wen <= x_wen;
            if (d_ready) begin
                x_v       <= 1'b1;
                x_rd      <= d_rd;
                x_wen     <= d_wen;
                x_load    <= d_is_load;
                fwd_a_sel <= sel_a;
                fwd_b_sel <= sel_b;
            end else begin
                x_v       <= 1'b0;
                x_rd      <= '0;
                x_wen     <= 1'b0;
                x_load    <= 1'b0;
                fwd_a_sel <= SEL_RF;
                fwd_b_sel <= SEL_RF;
            end
            x_bubble <= !d_ready;
            // A redirect squashes D, so its bubble is not a hazard bubble
            if (hazard && !x_redirect && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

    assign dbg_shadow = {x_v, x_rd, x_wen, x_load, w_v, w_rd, w_wen, r_v, r_rd, r_wen};

endmodule
